ring_switch_ctrl: RTL

RING_SWITCH_CTRL -- requirements
Module: ring_switch_ctrl

---
 rtl/ring_switch_ctrl_if.sv | 30 +++
 rtl/ring_switch_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ring_switch_ctrl_if.sv
// Handshake and mux-select bundle between a ring_switch_ctrl and its ring/NI/eject neighbours.
// The slave modport is the controller side; master is the environment side.
interface ring_switch_ctrl_if #(
  parameter int FLIT_W = 16
);
  logic [FLIT_W-1:0] ring_flit;
  logic              ring_valid;
  logic              ring_ready;
  logic [FLIT_W-1:0] ni_flit;
  logic              ni_valid;
  logic              noc_ready;
  logic              ring_out_ready;
  logic              eject_ready;
  logic              vc_sel;
  logic              sel_up;
  logic              sel_vc;
  logic              sel_NI;
  logic              flit_in_valid;
  logic              proto_err;

  modport slave (
    input  ring_flit, ring_valid, ni_flit, ni_valid, ring_out_ready, eject_ready,
    output ring_ready, noc_ready, vc_sel, sel_up, sel_vc, sel_NI, flit_in_valid, proto_err
  );

  modport master (
    output ring_flit, ring_valid, ni_flit, ni_valid, ring_out_ready, eject_ready,
    input  ring_ready, noc_ready, vc_sel, sel_up, sel_vc, sel_NI, flit_in_valid, proto_err
  );
endinterface

// File: rtl/ring_switch_ctrl.sv
// Wormhole ring switch controller: arbitrates upstream ring vs local NI, locks the path per packet.
// Define SWC_FAIRNESS_EN to add a starvation counter that forces a waiting NI head through.
module ring_switch_ctrl #(
  parameter int FLIT_W       = 16,
  parameter int NODE_W       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NODE_W-1:0] current_node,
  ring_switch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    EJECT = 2'd2,
    INJ   = 2'd3
  } state_e;

  localparam logic [1:0] TYPE_HEAD   = 2'b11;
  localparam logic [1:0] TYPE_TAIL   = 2'b01;
  localparam logic [1:0] TYPE_SINGLE = 2'b00;

  state_e     state_q, state_d;
  logic       vc_sel_q, vc_sel_d;
  logic       sel_up_q, sel_up_d;
  logic       sel_vc_q, sel_vc_d;
  logic       sel_ni_q, sel_ni_d;
  logic       proto_err_q, proto_err_d;
  logic       ring_ready_s, noc_ready_s, flit_in_valid_s;
  logic       ring_grant_s, ni_grant_s, ni_force_s;
  logic [1:0] ring_type_s, ni_type_s;
  logic       ring_head_s, ni_head_s, ring_last_s, ni_last_s, ring_local_s;
  logic       unused_s;

  assign ring_type_s  = bus.ring_flit[FLIT_W-1 -: 2];
  assign ni_type_s    = bus.ni_flit[FLIT_W-1 -: 2];
  assign ring_head_s  = bus.ring_valid && ((ring_type_s == TYPE_HEAD) || (ring_type_s == TYPE_SINGLE));
  assign ni_head_s    = bus.ni_valid && ((ni_type_s == TYPE_HEAD) || (ni_type_s == TYPE_SINGLE));
  assign ring_last_s  = (ring_type_s == TYPE_TAIL) || (ring_type_s == TYPE_SINGLE);
  assign ni_last_s    = (ni_type_s == TYPE_TAIL) || (ni_type_s == TYPE_SINGLE);
  assign ring_local_s = (bus.ring_flit[NODE_W-1:0] == current_node);
  assign unused_s     = ^{bus.ring_flit, bus.ni_flit};

`ifdef SWC_FAIRNESS_EN
  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign ni_force_s = ni_head_s && (starve_q == CNT_MAX);

  // Saturating count of ring grants that overtook a waiting NI head.
  always_comb begin
    starve_d = starve_q;
    if (ni_grant_s) begin
      starve_d = '0;
    end else if (ring_grant_s && ni_head_s && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + CNT_ONE;
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign ni_force_s = 1'b0;
`endif

  // Next-state, handshake and select decode.
  always_comb begin
    state_d         = state_q;
    ring_ready_s    = 1'b0;
    noc_ready_s     = 1'b0;
    flit_in_valid_s = 1'b0;
    proto_err_d     = proto_err_q;
    ring_grant_s    = 1'b0;
    ni_grant_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ni_force_s) begin
          ni_grant_s = 1'b1;
          state_d    = INJ;
        end else if (ring_head_s) begin
          ring_grant_s = 1'b1;
          state_d      = ring_local_s ? EJECT : FWD;
        end else if (ni_head_s) begin
          ni_grant_s = 1'b1;
          state_d    = INJ;
        end else begin
          state_d = IDLE;
        end
        // Orphan body/tail flits are drained so they cannot wedge the ring.
        if (bus.ring_valid && !ring_head_s) begin
          ring_ready_s = 1'b1;
          proto_err_d  = 1'b1;
        end else begin
          ring_ready_s = 1'b0;
        end
        if (bus.ni_valid && !ni_head_s && !ring_head_s) begin
          noc_ready_s = 1'b1;
          proto_err_d = 1'b1;
        end else begin
          noc_ready_s = 1'b0;
        end
      end
      FWD: begin
        ring_ready_s = bus.ring_out_ready;
        if (bus.ring_valid && bus.ring_out_ready && ring_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = FWD;
        end
      end
      EJECT: begin
        ring_ready_s    = bus.eject_ready;
        flit_in_valid_s = bus.ring_valid;
        if (bus.ring_valid && bus.eject_ready && ring_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = EJECT;
        end
      end
      INJ: begin
        noc_ready_s = bus.ring_out_ready;
        if (bus.ni_valid && bus.ring_out_ready && ni_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = INJ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    vc_sel_d = (state_d == FWD);
    sel_vc_d = (state_d == FWD);
    sel_up_d = (state_d == FWD) || (state_d == INJ);
    sel_ni_d = (state_d == INJ);
  end

  // FSM state, registered mux selects and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vc_sel_q    <= 1'b0;
      sel_up_q    <= 1'b0;
      sel_vc_q    <= 1'b0;
      sel_ni_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vc_sel_q    <= vc_sel_d;
      sel_up_q    <= sel_up_d;
      sel_vc_q    <= sel_vc_d;
      sel_ni_q    <= sel_ni_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Readies follow downstream readiness in the same cycle; reset forces them low.
  assign bus.ring_ready    = rst_n & ring_ready_s;
  assign bus.noc_ready     = rst_n & noc_ready_s;
  assign bus.flit_in_valid = rst_n & flit_in_valid_s;
  assign bus.vc_sel        = vc_sel_q;
  assign bus.sel_up        = sel_up_q;
  assign bus.sel_vc        = sel_vc_q;
  assign bus.sel_NI        = sel_ni_q;
  assign bus.proto_err     = proto_err_q;

endmodule
